// File: rtl/uart_frame_serializer.sv
// UART frame serializer: start, DATA_WIDTH data bits, optional parity, 1..2 stop bits.
// Parity exists only when UART_FRAME_SERIALIZER_PARITY_EN is defined.
module uart_frame_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int MSB_FIRST  = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bit_tick,
   input  logic [DATA_WIDTH-1:0] parallel_data,
   input  logic                  data_valid,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   output logic                  serial_data,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_WIDTH-1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt, shreg_adv;
   logic                  serial_nxt, busy_nxt, done_nxt;
   logic                  head_bit, par_active, par_bit;
   logic                  accept;

   assign accept = (state == IDLE) && data_valid;

   // Shift register always presents the next data bit at its head
   assign head_bit  = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
   assign shreg_adv = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg[DATA_WIDTH-1:1]};

`ifdef UART_FRAME_SERIALIZER_PARITY_EN
   logic par_en_q, par_bit_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else if (accept) begin
         par_en_q  <= parity_enable;
         par_bit_q <= (^parallel_data) ^ parity_type;
      end
   end

   assign par_active = par_en_q;
   assign par_bit    = par_bit_q;
`else
   logic unused_par;
   assign unused_par = parity_enable ^ parity_type;
   assign par_active = 1'b0;
   assign par_bit    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bit_idx     <= '0;
         shreg       <= '0;
         serial_data <= 1'b1;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_idx     <= bit_idx_nxt;
         shreg       <= shreg_nxt;
         serial_data <= serial_nxt;
         busy        <= busy_nxt;
         frame_done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (data_valid) state_nxt = START;
         START:   if (bit_tick) state_nxt = DATA;
         DATA:    if (bit_tick && bit_idx == LAST) state_nxt = par_active ? PARITY : STOP1;
`ifdef UART_FRAME_SERIALIZER_PARITY_EN
         PARITY:  if (bit_tick) state_nxt = STOP1;
`endif
         STOP1:   if (bit_tick) state_nxt = (STOP_BITS == 2) ? STOP2 : IDLE;
         STOP2:   if (bit_tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered line, handshake and datapath
   always_comb begin
      serial_nxt  = serial_data;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      case (state)
         IDLE: if (data_valid) begin
            shreg_nxt   = parallel_data;
            serial_nxt  = 1'b0;
            busy_nxt    = 1'b1;
            bit_idx_nxt = '0;
         end
         START: if (bit_tick) begin
            serial_nxt = head_bit;
            shreg_nxt  = shreg_adv;
         end
         DATA: if (bit_tick) begin
            if (bit_idx == LAST) begin
               bit_idx_nxt = '0;
               serial_nxt  = par_active ? par_bit : 1'b1;
            end else begin
               bit_idx_nxt = bit_idx + IDX_W'(1);
               serial_nxt  = head_bit;
               shreg_nxt   = shreg_adv;
            end
         end
`ifdef UART_FRAME_SERIALIZER_PARITY_EN
         PARITY: if (bit_tick) serial_nxt = 1'b1;
`endif
         STOP1: if (bit_tick) begin
            serial_nxt = 1'b1;
            if (STOP_BITS != 2) begin
               busy_nxt = 1'b0;
               done_nxt = 1'b1;
            end
         end
         STOP2: if (bit_tick) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
         end
         default: begin
            serial_nxt = 1'b1;
            busy_nxt   = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_frame_serializer.sv
// Scoreboard bench for uart_frame_serializer: LSB-first, MSB-first and 2-stop-bit instances.
module tb_uart_frame_serializer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bit_tick = 1'b0;
   logic       par_en = 1'b0;
   logic       par_type = 1'b0;
   logic [2:0] dv = '0;
   logic [7:0] pdata [3];
   logic [2:0] ser, busy, done;

   int n_vec = 0;
   int n_err = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   uart_frame_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .STOP_BITS(1)) u_lsb (
      .clk(clk), .reset(reset), .bit_tick(bit_tick), .parallel_data(pdata[0]),
      .data_valid(dv[0]), .parity_enable(par_en), .parity_type(par_type),
      .serial_data(ser[0]), .busy(busy[0]), .frame_done(done[0]));

   uart_frame_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .STOP_BITS(1)) u_msb (
      .clk(clk), .reset(reset), .bit_tick(bit_tick), .parallel_data(pdata[1]),
      .data_valid(dv[1]), .parity_enable(par_en), .parity_type(par_type),
      .serial_data(ser[1]), .busy(busy[1]), .frame_done(done[1]));

   uart_frame_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .STOP_BITS(2)) u_stp2 (
      .clk(clk), .reset(reset), .bit_tick(bit_tick), .parallel_data(pdata[2]),
      .data_valid(dv[2]), .parity_enable(par_en), .parity_type(par_type),
      .serial_data(ser[2]), .busy(busy[2]), .frame_done(done[2]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Idle cycles with ticks toggling: nothing may move without data_valid
   task automatic idle(input int u, input int n);
      for (int i = 0; i < n; i++) begin
         bit_tick = i[0];
         @(negedge clk);
         chk("idle_line", ser[u], 1'b1);
         chk("idle_busy", busy[u], 1'b0);
         chk("idle_done", done[u], 1'b0);
      end
      bit_tick = 1'b0;
   endtask

   // Push the expected line sequence, present the word, then tick through the frame
   task automatic send(input int u, input logic [7:0] d, input bit pe, input bit pt,
                       input bit hold, input int stall_at);
      bit e;
      int k;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(u == 1 ? d[7-i] : d[i]);
`ifdef UART_FRAME_SERIALIZER_PARITY_EN
      if (pe) exp_q.push_back((^d) ^ pt);
`endif
      for (int i = 0; i < (u == 2 ? 2 : 1); i++) exp_q.push_back(1'b1);

      par_en   = pe;
      par_type = pt;
      pdata[u] = d;
      dv[u]    = 1'b1;
      bit_tick = 1'b1;
      @(negedge clk);
      bit_tick = 1'b0;
      chk("accept_busy", busy[u], 1'b1);
      chk("accept_done", done[u], 1'b0);
      if (!hold) dv[u] = 1'b0;

      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("line", ser[u], e);
         chk("busy_mid", busy[u], 1'b1);
         chk("done_mid", done[u], 1'b0);
         if (k == stall_at) begin
            for (int c = 0; c < 50; c++) begin
               @(negedge clk);
               chk("stall_line", ser[u], e);
            end
            chk("stall_busy", busy[u], 1'b1);
         end else begin
            @(negedge clk);
            chk("gap_line", ser[u], e);
         end
         bit_tick = 1'b1;
         @(negedge clk);
         bit_tick = 1'b0;
         k++;
      end
      chk("done_pulse", done[u], 1'b1);
      chk("busy_fall", busy[u], 1'b0);
      chk("end_line", ser[u], 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) pdata[i] = 8'h00;
      #2 reset = 1'b0;
      #1;
      for (int u = 0; u < 3; u++) begin
         chk("rst_line", ser[u], 1'b1);
         chk("rst_busy", busy[u], 1'b0);
         chk("rst_done", done[u], 1'b0);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int u = 0; u < 3; u++) idle(u, 4);

      send(0, 8'hA5, 1'b0, 1'b0, 1'b0, -1);
      idle(0, 3);
      send(1, 8'hA5, 1'b0, 1'b0, 1'b0, -1);
      idle(1, 3);

      send(0, 8'hA5, 1'b1, 1'b0, 1'b0, -1);
      idle(0, 2);
      send(0, 8'h07, 1'b1, 1'b1, 1'b0, -1);
      idle(0, 2);
      send(0, 8'h07, 1'b1, 1'b0, 1'b0, -1);
      idle(0, 2);

      send(2, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
      send(2, 8'hC3, 1'b0, 1'b0, 1'b0, -1);
      idle(2, 3);

      send(0, 8'h5A, 1'b0, 1'b0, 1'b0, 4);
      idle(0, 2);

      // Abort a frame of zeros while the line is low
      pdata[0] = 8'h00;
      dv[0]    = 1'b1;
      @(negedge clk);
      dv[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bit_tick = 1'b1;
         @(negedge clk);
         bit_tick = 1'b0;
         @(negedge clk);
      end
      chk("pre_abort_line", ser[0], 1'b0);
      reset = 1'b0;
      #1;
      chk("abort_line", ser[0], 1'b1);
      chk("abort_busy", busy[0], 1'b0);
      chk("abort_done", done[0], 1'b0);
      @(negedge clk);
      reset = 1'b1;
      idle(0, 6);
      send(0, 8'h81, 1'b0, 1'b0, 1'b0, -1);
      idle(0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_frame_serializer.md
Name: uart_frame_serializer

Overview:
- Parametrised successor to the UART transmitter bit serializer.
- Owns its own bit-index counter and framing state machine, so the transmitter FSM does not have to sequence it bit by bit.
- Accepts one parallel word by valid/busy handshake. Emits start bit, DATA_WIDTH data bits (LSB- or MSB-first), optional parity and 1 or 2 stop bits.
- Advances one bit per baud tick from the clock divider and drives the UART TX line directly.

Parameters:
- DATA_WIDTH, 8: data bits per frame; legal range 5..16.
- MSB_FIRST, 0: 0 = bit 0 sent first; 1 = bit DATA_WIDTH-1 sent first.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1: generated clock from the clock divider, sourced by the UART clock.
- reset  input  1: global asynchronous active-low reset, after synchronization.
- bit_tick  input  1: one-cycle baud enable; each tick ends the current bit period.
- parallel_data  input  DATA_WIDTH: word to transmit; sampled only on acceptance.
- data_valid  input  1: request to send parallel_data.
- parity_enable  input  1: 1 = insert parity bit (used only with the macro).
- parity_type  input  1: 0 = even, 1 = odd (used only with the macro).
- serial_data  output  1: registered TX line; idle high.
- busy  output  1: registered; high from acceptance until frame end.
- frame_done  output  1: registered one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset (async, active-low):
  - Outputs: serial_data=1, busy=0, frame_done=0.
  - Internals: state=IDLE, bit index=0, shift register=0.
  - Reset asserted mid-frame aborts the frame immediately. The line returns to 1 and frame_done is not pulsed.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. The state names the bit currently on the line.
- Acceptance: in IDLE with data_valid=1 (bit_tick irrelevant), on that edge:
  - latch parallel_data;
  - state<=START, serial_data<=0, busy<=1, bit index<=0;
  - latch parity_enable and parity_type.
- data_valid while busy=1 is ignored; no queueing. Upstream holds data_valid until busy is seen high.
- All transitions below occur only on edges where bit_tick=1; without a tick, state and serial_data hold.
- START -> DATA: drive the first data bit.
  - MSB_FIRST=0: data[0].
  - MSB_FIRST=1: data[DATA_WIDTH-1].
- DATA, bit index < DATA_WIDTH-1: index+1, drive the next bit in the selected order.
- DATA, bit index = DATA_WIDTH-1:
  - to PARITY if parity is active (macro defined and latched parity_enable=1), driving the parity bit;
  - otherwise to STOP1, driving 1.
  - The index wraps to 0.
- PARITY -> STOP1: drive 1.
- STOP1:
  - STOP_BITS=2: -> STOP2, drive 1.
  - STOP_BITS=1: -> IDLE, busy<=0, frame_done<=1.
- STOP2 -> IDLE: busy<=0, frame_done<=1.
- frame_done is high for exactly one clk cycle and deasserts on the next edge.
- Back-to-back frames: a new word may be accepted on the edge after busy falls, i.e. the cycle frame_done is high, if data_valid=1. Minimum idle gap is one clk, not one bit period.
- Bit timing:
  - START lasts from acceptance to the first bit_tick. The divider restarts its count when busy rises so START is a full period.
  - Every other bit lasts exactly one tick interval.
- bit_tick coincident with acceptance has no effect beyond acceptance.
- Bit index width is $clog2(DATA_WIDTH); the counter never exceeds DATA_WIDTH-1.
- Frame length in ticks: 1 + DATA_WIDTH + P + STOP_BITS, where P is 1 if parity is active, else 0.

Optional Feature:
- Macro: UART_FRAME_SERIALIZER_PARITY_EN.
- Defined:
  - Parity register computed at acceptance as the XOR of the latched data, inverted when parity_type=1.
  - PARITY state reachable when latched parity_enable=1.
- Undefined:
  - No parity logic or PARITY state is synthesised.
  - parity_enable and parity_type stay as ports but are ignored.
  - Frames never carry parity.

Test Plan:
- Reset/idle: hold reset=0 mid-frame, then release -> serial_data=1, busy=0, frame_done=0 immediately. No activity until data_valid.
- LSB-first 0xA5, no parity, STOP_BITS=1 -> line per tick: 0,1,0,1,0,0,1,0,1,1. busy high for 10 ticks. frame_done is a single pulse at the end.
- MSB_FIRST=1, 0xA5 -> data bits on line 1,0,1,0,0,1,0,1 between start 0 and stop 1.
- Macro defined, 0xA5 with even parity, then 0x07 with odd parity -> parity bit 0 for 0xA5, 0 for 0x07. Frame is 11 ticks. Repeat with the macro undefined -> 10 ticks, no parity bit.
- STOP_BITS=2, back-to-back 0x3C then 0xC3 with data_valid held high -> line high for 2 ticks after the last data bit. Second start bit begins one clk after frame_done. data_valid during busy is not double-accepted.
- No bit_tick for 50 clk mid-DATA -> serial_data and state frozen; resumes correctly on the next tick.
